// File: rtl/axis_gearbox_if.sv
// AXI4-Stream bus bundle used on both sides of axis_gearbox.
// The keep width follows from the data width; master drives the payload, slave drives tready.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_gearbox.sv
// AXI4-Stream byte-lane gearbox: repacks S input lanes into M output lanes through a byte FIFO.
// Define AXIS_GEARBOX_COMPACT_EN to accept sparse s_axis tkeep (kept lanes compacted in ascending order).
module axis_gearbox #(
    parameter int unsigned S_DATA_WIDTH = 24,
    parameter int unsigned M_DATA_WIDTH = 16,
    parameter int unsigned ID_ENABLE    = 0,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned DEST_ENABLE  = 0,
    parameter int unsigned DEST_WIDTH   = 8,
    parameter int unsigned USER_ENABLE  = 1,
    parameter int unsigned USER_WIDTH   = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    axis_if.slave  s_axis,
    axis_if.master m_axis
);
    localparam int unsigned S   = S_DATA_WIDTH / 8;
    localparam int unsigned M   = M_DATA_WIDTH / 8;
    localparam int unsigned BUF = S + M;
    localparam int unsigned BW  = 8 * BUF;
    localparam int unsigned CW  = $clog2(BUF + 1);

    logic [BUF-1:0][7:0]   buf_q, buf_n;
    logic [CW-1:0]         cnt_q, cnt_n;
    logic                  flush_q, flush_n;
    logic                  empty_q, empty_n;
    logic                  sof_q, sof_n;
    logic [ID_WIDTH-1:0]   id_q, id_n;
    logic [DEST_WIDTH-1:0] dest_q, dest_n;
    logic [USER_WIDTH-1:0] user_q, user_n;

    logic [S-1:0][7:0]     in_bytes, ins;
    logic [CW-1:0]         push, pop, base, avail;
    logic                  s_fire, m_fire;
    logic                  valid_n, last_n, ready_n;
    logic [M-1:0]          keep_n;
    logic [M_DATA_WIDTH-1:0] data_n;

    assign s_fire = s_axis.tvalid && s_axis.tready;
    assign m_fire = m_axis.tvalid && m_axis.tready;

    // Gather the accepted bytes into in_bytes[0..push-1]
    always_comb begin
        in_bytes = '0;
        push     = '0;
`ifdef AXIS_GEARBOX_COMPACT_EN
        for (int unsigned k = 0; k < S; k++) begin
            if (s_axis.tkeep[k]) begin
                for (int unsigned j = 0; j < S; j++) begin
                    if (CW'(j) == push) in_bytes[j] = s_axis.tdata[8*k +: 8];
                end
                push = push + CW'(1);
            end
        end
`else
        for (int unsigned k = 0; k < S; k++) begin
            in_bytes[k] = s_axis.tdata[8*k +: 8];
            push        = push + CW'(s_axis.tkeep[k]);
        end
`endif
    end

    // Next buffer state: shift out popped bytes, append pushed bytes behind the survivors
    always_comb begin
        buf_n   = buf_q;
        cnt_n   = cnt_q;
        flush_n = flush_q;
        empty_n = empty_q;
        sof_n   = sof_q;
        id_n    = id_q;
        dest_n  = dest_q;
        user_n  = user_q;
        pop     = '0;
        ins     = '0;

        if (m_fire) pop = (cnt_q < CW'(M)) ? cnt_q : CW'(M);
        base = cnt_q - pop;
        for (int unsigned k = 0; k < S; k++) begin
            if (CW'(k) < push) ins[k] = in_bytes[k];
        end

        buf_n = buf_q >> {pop, 3'b000};
        cnt_n = base;

        if (s_fire) begin
            buf_n = buf_n | (BW'(ins) << {base, 3'b000});
            cnt_n = base + push;
            if (sof_q) begin
                sof_n = 1'b0;
                if (ID_ENABLE != 0)   id_n   = s_axis.tid;
                if (DEST_ENABLE != 0) dest_n = s_axis.tdest;
            end
            if (s_axis.tlast) begin
                flush_n = 1'b1;
                if (USER_ENABLE != 0) user_n = s_axis.tuser;
                // Frame ends with nothing left to carry its tlast: emit a keep-less beat
                if (cnt_n == '0) empty_n = 1'b1;
            end
        end

        if (m_fire && m_axis.tlast) begin
            flush_n = 1'b0;
            empty_n = 1'b0;
            sof_n   = 1'b1;
        end
    end

    // Output beat derived from next state so every port comes straight from a flop
    always_comb begin
        avail   = (cnt_n < CW'(M)) ? cnt_n : CW'(M);
        valid_n = (cnt_n >= CW'(M)) || (flush_n && (cnt_n != '0)) || empty_n;
        last_n  = flush_n && (cnt_n <= CW'(M));
        ready_n = !flush_n && (cnt_n <= CW'(M));
        keep_n  = '0;
        data_n  = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (CW'(k) < avail) begin
                keep_n[k]         = 1'b1;
                data_n[8*k +: 8]  = buf_n[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q         <= '0;
            cnt_q         <= '0;
            flush_q       <= 1'b0;
            empty_q       <= 1'b0;
            sof_q         <= 1'b1;
            id_q          <= '0;
            dest_q        <= '0;
            user_q        <= '0;
            s_axis.tready <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tid    <= '0;
            m_axis.tdest  <= '0;
            m_axis.tuser  <= '0;
        end else begin
            buf_q         <= buf_n;
            cnt_q         <= cnt_n;
            flush_q       <= flush_n;
            empty_q       <= empty_n;
            sof_q         <= sof_n;
            id_q          <= id_n;
            dest_q        <= dest_n;
            user_q        <= user_n;
            s_axis.tready <= ready_n;
            m_axis.tvalid <= valid_n;
            m_axis.tdata  <= data_n;
            m_axis.tkeep  <= keep_n;
            m_axis.tlast  <= last_n;
            m_axis.tid    <= id_n;
            m_axis.tdest  <= dest_n;
            m_axis.tuser  <= last_n ? user_n : '0;
        end
    end
endmodule

// File: tb/tb_axis_gearbox.sv
// Scoreboard bench for axis_gearbox: a 3->2 lane instance for directed cases and a 2->5 lane
// instance with tid/tdest enabled for random frames under random backpressure.
module tb_axis_gearbox;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [7:0]  id;
        logic [7:0]  dest;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    beat_t ea, eb;
    logic [7:0] bq[$];
    int n_tests = 0;
    int n_fail  = 0;
    int b_in = 0, b_out = 0, b_max_occ = 0;

    axis_if #(.DATA_WIDTH(24)) a_s ();
    axis_if #(.DATA_WIDTH(16)) a_m ();
    axis_if #(.DATA_WIDTH(16)) b_s ();
    axis_if #(.DATA_WIDTH(40)) b_m ();

    axis_gearbox #(.S_DATA_WIDTH(24), .M_DATA_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis(a_s), .m_axis(a_m));

    axis_gearbox #(.S_DATA_WIDTH(16), .M_DATA_WIDTH(40), .ID_ENABLE(1), .DEST_ENABLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis(b_s), .m_axis(b_m));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: bytes chunked into m-lane beats, tlast/tuser on the final beat
    function automatic void model_push(input int which, input logic [7:0] bytes[$], input int m,
                                       input logic user, input logic [7:0] id, input logic [7:0] dest);
        beat_t b;
        int n = bytes.size();
        if (n == 0) begin
            b = '0; b.last = 1'b1; b.user = user; b.id = id; b.dest = dest;
            if (which == 0) qa.push_back(b); else qb.push_back(b);
            return;
        end
        for (int base = 0; base < n; base += m) begin
            b = '0;
            for (int k = 0; k < m && base + k < n; k++) begin
                b.data[8*k +: 8] = bytes[base + k];
                b.keep[k] = 1'b1;
            end
            b.last = (base + m >= n);
            b.user = b.last ? user : 1'b0;
            b.id = id; b.dest = dest;
            if (which == 0) qa.push_back(b); else qb.push_back(b);
        end
    endfunction

    task automatic send_a(input logic [23:0] d, input logic [2:0] k, input logic l, input logic u);
        int n = 0;
        a_s.tdata = d; a_s.tkeep = k; a_s.tlast = l; a_s.tuser = u; a_s.tvalid = 1'b1;
        while (!a_s.tready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check("a_send_timeout", 64'd1, 64'd0);
        else @(negedge clk);
        a_s.tvalid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic [1:0] k, input logic l, input logic u,
                          input logic [7:0] id, input logic [7:0] dest);
        int n = 0;
        b_s.tdata = d; b_s.tkeep = k; b_s.tlast = l; b_s.tuser = u;
        b_s.tid = id; b_s.tdest = dest; b_s.tvalid = 1'b1;
        while (!b_s.tready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) check("b_send_timeout", 64'd1, 64'd0);
        else begin b_in += $countones(k); @(negedge clk); end
        b_s.tvalid = 1'b0;
    endtask

    // Contiguous 1..n byte frame on instance A
    task automatic frame_a(input int n, input logic user);
        logic [23:0] d;
        logic [2:0]  k;
        bq.delete();
        for (int i = 1; i <= n; i++) bq.push_back(8'(i));
        model_push(0, bq, 2, user, 8'h00, 8'h00);
        for (int base = 0; base < n; base += 3) begin
            d = '0; k = '0;
            for (int j = 0; j < 3; j++) begin
                if (base + j < n) begin d[8*j +: 8] = bq[base + j]; k[j] = 1'b1; end
            end
            send_a(d, k, base + 3 >= n, (base + 3 >= n) ? user : 1'b0);
        end
    endtask

    task automatic drain(input int which);
        for (int n = 0; n < 2000 && ((which == 0) ? qa.size() : qb.size()) != 0; n++) @(negedge clk);
        check((which == 0) ? "a_drain" : "b_drain", 64'((which == 0) ? qa.size() : qb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && a_m.tvalid && a_m.tready) begin
            if (qa.size() == 0) check("a_unexpected_beat", 64'(a_m.tdata), 64'hDEAD_0000_0000_0000);
            else begin
                ea = qa.pop_front();
                check("a_data", 64'(a_m.tdata), ea.data);
                check("a_keep", 64'(a_m.tkeep), 64'(ea.keep));
                check("a_last", 64'(a_m.tlast), 64'(ea.last));
                check("a_user", 64'(a_m.tuser), 64'(ea.user));
                check("a_id",   64'(a_m.tid),   64'(ea.id));
                check("a_dest", 64'(a_m.tdest), 64'(ea.dest));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_m.tvalid && b_m.tready) begin
            b_out += $countones(b_m.tkeep);
            if (qb.size() == 0) check("b_unexpected_beat", 64'(b_m.tdata), 64'hDEAD_0000_0000_0000);
            else begin
                eb = qb.pop_front();
                check("b_data", 64'(b_m.tdata), eb.data);
                check("b_keep", 64'(b_m.tkeep), 64'(eb.keep));
                check("b_last", 64'(b_m.tlast), 64'(eb.last));
                check("b_user", 64'(b_m.tuser), 64'(eb.user));
                check("b_id",   64'(b_m.tid),   64'(eb.id));
                check("b_dest", 64'(b_m.tdest), 64'(eb.dest));
            end
        end
    end

    // Random sink backpressure on B; occupancy tracked from observed transfers
    initial forever begin
        @(posedge clk);
        #1 b_m.tready = 1'($urandom_range(0, 1));
        #1 if (b_in - b_out > b_max_occ) b_max_occ = b_in - b_out;
    end

    initial begin
        logic [7:0] id, dest;
        logic       user;
        int         len;
        logic [15:0] d;

        a_s.tvalid = 0; a_s.tdata = '0; a_s.tkeep = '0; a_s.tlast = 0;
        a_s.tid = '0; a_s.tdest = '0; a_s.tuser = '0; a_m.tready = 1'b1;
        b_s.tvalid = 0; b_s.tdata = '0; b_s.tkeep = '0; b_s.tlast = 0;
        b_s.tid = '0; b_s.tdest = '0; b_s.tuser = '0; b_m.tready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a_tready", 64'(a_s.tready), 64'd0);
        check("rst_a_tvalid", 64'(a_m.tvalid), 64'd0);
        check("rst_a_tdata",  64'(a_m.tdata),  64'd0);
        check("rst_a_tkeep",  64'(a_m.tkeep),  64'd0);
        check("rst_a_tlast",  64'(a_m.tlast),  64'd0);
        check("rst_b_tready", 64'(b_s.tready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("a_tready_first_edge", 64'(a_s.tready), 64'd1);
        @(negedge clk);

        frame_a(6, 1'b0);                      // 0x0201, 0x0403, 0x0605 last
        frame_a(5, 1'b0);                      // residue 0x0005 keep 01 last
        frame_a(4, 1'b1);                      // tuser only on the tlast output beat

        // zero-keep non-last beat mid-frame is discarded
        bq.delete();
        for (int i = 1; i <= 5; i++) bq.push_back(8'(i));
        model_push(0, bq, 2, 1'b0, 8'h00, 8'h00);
        send_a(24'h030201, 3'b111, 1'b0, 1'b0);
        send_a(24'h000000, 3'b000, 1'b0, 1'b0);
        send_a(24'h000504, 3'b011, 1'b1, 1'b0);

        // empty frame: one keep-less tlast beat
        bq.delete();
        model_push(0, bq, 2, 1'b1, 8'h00, 8'h00);
        send_a(24'h000000, 3'b000, 1'b1, 1'b1);

`ifdef AXIS_GEARBOX_COMPACT_EN
        bq.delete(); bq.push_back(8'hAA); bq.push_back(8'hCC);
        model_push(0, bq, 2, 1'b0, 8'h00, 8'h00);
        send_a(24'hCC00AA, 3'b101, 1'b1, 1'b0);
`endif
        drain(0);

        // reset mid-frame with four bytes buffered and the sink stalled
        @(posedge clk);
        #1 a_m.tready = 1'b0;
        @(negedge clk);
        send_a(24'h000011, 3'b001, 1'b0, 1'b0);
        send_a(24'h444332, 3'b111, 1'b0, 1'b0);
        check("a_tvalid_before_rst", 64'(a_m.tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("a_tvalid_in_rst", 64'(a_m.tvalid), 64'd0);
        check("a_tready_in_rst", 64'(a_s.tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 a_m.tready = 1'b1;
        @(negedge clk);
        bq.delete();
        for (int i = 1; i <= 3; i++) bq.push_back(8'(i));
        model_push(0, bq, 2, 1'b0, 8'h00, 8'h00);
        send_a(24'h030201, 3'b111, 1'b1, 1'b0);
        drain(0);

        // random frames on the 2->5 instance
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 40);
            id = 8'($urandom); dest = 8'($urandom); user = 1'($urandom_range(0, 1));
            bq.delete();
            for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            model_push(1, bq, 5, user, id, dest);
            for (int base = 0; base < len; base += 2) begin
                d = {(base + 1 < len) ? bq[base + 1] : 8'h00, bq[base]};
                send_b(d, (base + 1 < len) ? 2'b11 : 2'b01, base + 2 >= len,
                       (base + 2 >= len) ? user : ~user,
                       (base == 0) ? id : ~id, (base == 0) ? dest : ~dest);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end
        drain(1);
        check("b_byte_balance", 64'(b_out), 64'(b_in));
        check("b_occupancy_le_buf", 64'(b_max_occ > 7), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_gearbox.md
# axis_gearbox

AXI4-Stream byte-lane gearbox that converts between arbitrary input and output byte-lane counts, including non-integer ratios such as 3:2 or 2:5, unlike a power-of-two width adapter. Bytes are packed into an internal byte FIFO and repacked to the output width. Frames are preserved: tlast flushes the residue as a short final beat. The block sits between stream sources and sinks whose datapath widths differ, such as a 24-bit video pipe feeding a 16-bit DMA.

## Interface
- S_DATA_WIDTH, 24, input data width; multiple of 8.
- M_DATA_WIDTH, 16, output data width; multiple of 8.
- ID_ENABLE, 0, propagate tid.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, propagate tdest.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, propagate tuser.
- USER_WIDTH, 1, tuser width.
- Derived values: S = S_DATA_WIDTH/8, M = M_DATA_WIDTH/8, BUF = S+M byte lanes.

Ports:
- clk, input, 1, clock; the only clock.
- rst_n, input, 1, reset; asynchronous assert, active-low.
- s_axis_tdata / tkeep / tvalid / tready / tlast / tid / tdest / tuser, in/in/in/out/in/in/in/in, S_DATA_WIDTH / S / 1 / 1 / 1 / ID_WIDTH / DEST_WIDTH / USER_WIDTH, input stream.
- m_axis_tdata / tkeep / tvalid / tready / tlast / tid / tdest / tuser, out/out/out/in/out/out/out/out, M_DATA_WIDTH / M / 1 / 1 / 1 / ID_WIDTH / DEST_WIDTH / USER_WIDTH, output stream.

## Operation
- State:
  - byte buffer buf[BUF];
  - count cnt, range 0..BUF;
  - flush flag;
  - frame-start flag sof;
  - latched tid, tdest and tuser.
- Input acceptance:
  - s_axis_tready = !flush && cnt <= M.
  - On accept, kept input bytes append at buf[cnt - pop + k] in ascending lane order.
  - pop is the number of bytes removed in the same cycle.
- Output presentation:
  - Output lanes are buf[0..M-1].
  - m_axis_tvalid = (cnt >= M) || (flush && cnt > 0) || empty_pend.
  - tkeep[i] = (i < min(cnt, M)).
  - tlast = flush && cnt <= M.
  - Unkept lanes of tdata are 0.
- Output handshake: on m_axis_tvalid && m_axis_tready, pop = min(cnt, M) and the buffer shifts down by pop lanes.
- tlast handling:
  - An accepted beat with tlast sets flush.
  - flush clears when the tlast output beat is transferred; sof is then set.
  - While flush is set, no input is accepted, so frames never mix.
- Sideband:
  - tid and tdest are latched from the first accepted beat of a frame (sof) and held on every output beat of that frame.
  - tuser is latched from the tlast input beat; it drives output tuser on the tlast output beat and 0 on all other beats.
- Empty frame: a tlast beat with zero kept bytes while cnt == 0 sets empty_pend, which emits exactly one beat with tkeep=0, tlast=1.
- Zero-keep non-last beats are accepted and discarded.
- Width rules:
  - cnt width is $clog2(BUF+1).
  - push ≤ S and pop ≤ M; cnt never exceeds BUF.
  - S == M is legal and acts as a registered repacker.

## Timing
- Reset (rst_n low, asynchronous):
  - cnt=0, flush=0, empty_pend=0, sof=1.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tid/tdest/tuser=0.
  - s_axis_tready=0 while rst_n is low.
- After rst_n deasserts, s_axis_tready=1 on the first clock edge.
- Latency: a byte accepted at edge N is visible on the output after edge N if it falls within buf[0..M-1] and the valid condition holds.
- There is no combinational path from the s_axis inputs or m_axis_tready to any output.
- Simultaneous push and pop in one cycle are both applied: cnt_next = cnt - pop + push.
- Any m_axis_tvalid=1 with m_axis_tready=0 holds all m_axis outputs stable.
- Reset mid-frame discards buffered bytes and drops the partial frame; no tlast is emitted for it.

## Configuration
- AXIS_GEARBOX_COMPACT_EN defined:
  - s_axis_tkeep may be sparse; set lanes are compacted in ascending order.
  - push = popcount(tkeep).
- Not defined:
  - tkeep must be contiguous from lane 0; the compaction mux is omitted.
  - push = popcount(tkeep), and bytes are taken from lanes 0..push-1.
  - Sparse tkeep produces undefined data, but cnt stays consistent.

## Test plan
1. S=3, M=2; input 0x030201 then 0x060504 with tlast, tready=1 → outputs 0x0201, 0x0403, 0x0605 (tlast); all tkeep=2'b11.
2. S=3, M=2; 0x030201 keep 3'b111, then 0x__0504 keep 3'b011 with tlast → 0x0201, 0x0403, 0x0005 with keep 2'b01 and tlast=1.
3. S=2, M=5; 100 random frames of 1–40 bytes, m_axis_tready random at 50% → byte stream, frame boundaries and tid/tdest match the scoreboard; never more than BUF bytes buffered.
4. S=3, M=2, COMPACT_EN; beat 0xCC_xx_AA with keep 3'b101 and tlast → single beat 0xCCAA, keep 2'b11, tlast=1.
5. Frame with tuser=1 on its last input beat → tuser=1 only on the output tlast beat. A zero-keep tlast beat on an empty buffer → one beat with tkeep=0, tlast=1.
6. rst_n pulsed low mid-frame while cnt=4 → m_axis_tvalid drops immediately. The next frame 0x030201 with tlast → 0x0201, then 0x0003 (keep 2'b01, tlast), with no stale bytes.
